// File: rtl/modsq_pkg.sv
// Shared definitions for the modular-squaring normalizer slice.
// Holds the coefficient geometry, the coefficient/word types and the
// normalizer FSM state encoding.
package modsq_pkg;

   localparam int MOD_LEN            = 1024;
   localparam int WORD_LEN           = 16;
   localparam int BIT_LEN            = 17;
   localparam int REDUNDANT_ELEMENTS = 2;
   localparam int NUM_ELEMENTS       = MOD_LEN / WORD_LEN + REDUNDANT_ELEMENTS;

   typedef logic [BIT_LEN-1:0]  coeff_t;
   typedef logic [WORD_LEN-1:0] word_t;

   typedef enum logic [1:0] {IDLE, RUN, DONE} norm_state_t;

endpackage

// File: rtl/modsq_carry_step.sv
// One carry-propagation slice: coeff + carry_in -> radix word + carry_next.
// Ports:
//   coeff      - incoming 17-bit redundant coefficient
//   carry      - carry from the previous (less significant) word, 0..2
//   word       - low WORD_LEN bits of the sum
//   carry_next - sum >> WORD_LEN; never exceeds 2 for legal inputs
module modsq_carry_step
   import modsq_pkg::*;
(
   input  coeff_t     coeff,
   input  logic [1:0] carry,
   output word_t      word,
   output logic [1:0] carry_next
);

   // 0x1FFFF + 2 = 0x20001, so BIT_LEN+1 bits hold every reachable sum.
   logic [BIT_LEN:0] sum;

   assign sum        = {1'b0, coeff} + {{(BIT_LEN-1){1'b0}}, carry};
   assign word       = sum[WORD_LEN-1:0];
   assign carry_next = sum[WORD_LEN +: 2];

endmodule

// File: rtl/modsq_poly_normalizer.sv
// Converts the redundant-coefficient output of the modular squarer into a
// canonical binary integer, one coefficient per cycle, LSW first.
// Ports:
//   clk, reset    - clock, asynchronous active-high reset
//   sq_in         - NUM_ELEMENTS 32-bit slots, low BIT_LEN bits used
//   sq_valid      - one-cycle pulse qualifying sq_in
//   result        - normalized integer, held until the next completion
//   result_valid  - one-cycle pulse when result/carry_out update
//   carry_out     - carry beyond the top word, held with result
//   busy          - conversion in progress (RUN and DONE)
//   overrun       - sticky: sq_valid arrived while busy (cleared by reset)
module modsq_poly_normalizer #(
   parameter int MOD_LEN            = modsq_pkg::MOD_LEN,
   parameter int WORD_LEN           = modsq_pkg::WORD_LEN,
   parameter int BIT_LEN            = modsq_pkg::BIT_LEN,
   parameter int REDUNDANT_ELEMENTS = modsq_pkg::REDUNDANT_ELEMENTS,
   parameter int NUM_ELEMENTS       = MOD_LEN / WORD_LEN + REDUNDANT_ELEMENTS,
   parameter int SQ_IN_BITS         = NUM_ELEMENTS * WORD_LEN * 2,
   parameter int RESULT_BITS        = NUM_ELEMENTS * WORD_LEN
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [SQ_IN_BITS-1:0]  sq_in,
   input  logic                   sq_valid,
   output logic [RESULT_BITS-1:0] result,
   output logic                   result_valid,
   output logic [1:0]             carry_out,
   output logic                   busy,
   output logic                   overrun
);

   import modsq_pkg::*;

   localparam int SLOT_W = 2 * WORD_LEN;
   localparam int IDX_W  = $clog2(NUM_ELEMENTS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMENTS - 1);

   norm_state_t                            state;
   logic [IDX_W-1:0]                       index;
   logic [1:0]                             carry;
   logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]   coeffs;
   logic [RESULT_BITS-1:0]                 work;

   word_t      step_word;
   logic [1:0] step_carry;

   // Slot bits above BIT_LEN are don't-care by definition.
   logic unused_slot_bits;
   assign unused_slot_bits = ^sq_in;

   // The current coefficient is always at the bottom of the shift register.
   modsq_carry_step u_step (
      .coeff      (coeffs[0]),
      .carry      (carry),
      .word       (step_word),
      .carry_next (step_carry)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         index        <= '0;
         carry        <= '0;
         coeffs       <= '0;
         work         <= '0;
         result       <= '0;
         result_valid <= 1'b0;
         carry_out    <= '0;
         busy         <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         if (sq_valid && state != IDLE)
            overrun <= 1'b1;

         case (state)
            IDLE: begin
               if (sq_valid) begin
                  for (int j = 0; j < NUM_ELEMENTS; j++)
                     coeffs[j] <= sq_in[j*SLOT_W +: BIT_LEN];
                  carry <= '0;
                  index <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               // New words enter at the top; after NUM_ELEMENTS shifts
               // word 0 has reached the bottom, i.e. work[index] ordering.
               work   <= {step_word, work[RESULT_BITS-1:WORD_LEN]};
               coeffs <= {{BIT_LEN{1'b0}}, coeffs[NUM_ELEMENTS-1:1]};
               carry  <= step_carry;
               index  <= index + 1'b1;
               if (index == LAST_IDX)
                  state <= DONE;
            end
            DONE: begin
               result       <= work;
               carry_out    <= carry;
               result_valid <= 1'b1;
               busy         <= 1'b0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A 17-bit coefficient plus a carry of at most 2 can never carry 3.
   always @(posedge clk) begin
      if (!reset && state == RUN)
         assert (step_carry != 2'd3);
   end

endmodule

// File: tb/tb_modsq_poly_normalizer.sv
module tb_modsq_poly_normalizer;

   localparam int NE   = 66;
   localparam int WL   = 16;
   localparam int RB   = NE * WL;
   localparam int SQB  = NE * 32;
   localparam int LAT  = NE + 1;

   logic           clk = 1'b0;
   logic           reset;
   logic [SQB-1:0] sq_in;
   logic           sq_valid;
   logic [RB-1:0]  result;
   logic           result_valid;
   logic [1:0]     carry_out;
   logic           busy;
   logic           overrun;

   int passed = 0;
   int total  = 0;

   logic [16:0]    coef [NE];
   logic [SQB-1:0] bus;
   logic [RB-1:0]  exp_res;
   logic [1:0]     exp_co;

   modsq_poly_normalizer dut (
      .clk          (clk),
      .reset        (reset),
      .sq_in        (sq_in),
      .sq_valid     (sq_valid),
      .result       (result),
      .result_valid (result_valid),
      .carry_out    (carry_out),
      .busy         (busy),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   // Reference: the plain integer sum of c_j * 2^(16j), split into the
   // RB-bit result and whatever spills above it.
   task automatic compute_expected();
      logic [RB+1:0] acc;
      logic [RB+1:0] term;
      acc = '0;
      for (int j = 0; j < NE; j++) begin
         term = '0;
         term[16:0] = coef[j];
         acc = acc + (term << (WL * j));
      end
      exp_res = acc[RB-1:0];
      exp_co  = acc[RB+1:RB];
   endtask

   // Pack coefficients into slots; optionally fill ignored upper bits with junk.
   task automatic make_bus(input bit junk);
      logic [31:0] slot;
      for (int j = 0; j < NE; j++) begin
         slot = junk ? $urandom : 32'h0;
         slot[16:0] = coef[j];
         bus[j*32 +: 32] = slot;
      end
   endtask

   function automatic int first_diff(input logic [RB-1:0] a, input logic [RB-1:0] b);
      for (int j = 0; j < NE; j++)
         if (a[j*WL +: WL] !== b[j*WL +: WL]) return j;
      return -1;
   endfunction

   // Drive one sq_valid pulse; returns at the negedge just after the sampling edge.
   task automatic pulse();
      @(negedge clk);
      sq_in    = bus;
      sq_valid = 1'b1;
      @(negedge clk);
      sq_valid = 1'b0;
      sq_in    = {SQB/32{$urandom}};
   endtask

   // Count cycles until result_valid is seen; -1 if it never comes.
   task automatic wait_valid(output int lat);
      bit seen;
      seen = 0;
      lat  = -1;
      for (int k = 1; k <= 200 && !seen; k++) begin
         @(negedge clk);
         if (result_valid) begin
            seen = 1;
            lat  = k;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (result !== '0) $display("FAIL reset_result word%0d nonzero", first_diff(result, '0)); else passed++;
      total++; if (result_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", result_valid); else passed++;
      total++; if (carry_out !== 2'd0) $display("FAIL reset_carry got %0d exp 0", carry_out); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passed++;
      total++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %b exp 0", overrun); else passed++;
   endtask

   task automatic test_zero();
      int busy_cnt;
      int lat;
      for (int j = 0; j < NE; j++) coef[j] = '0;
      make_bus(0);
      compute_expected();
      pulse();
      total++; if (busy !== 1'b1) $display("FAIL zero_busy_rise got %b exp 1", busy); else passed++;
      busy_cnt = 0;
      lat = -1;
      for (int k = 1; k <= LAT + 5; k++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (result_valid && lat < 0) lat = k;
      end
      total++; if (lat !== LAT) $display("FAIL zero_latency got %0d exp %0d", lat, LAT); else passed++;
      total++; if (busy_cnt !== LAT - 1) $display("FAIL zero_busy_cycles got %0d exp %0d", busy_cnt, LAT - 1); else passed++;
      total++; if (result !== exp_res) $display("FAIL zero_result word%0d differs", first_diff(result, exp_res)); else passed++;
      total++; if (carry_out !== exp_co) $display("FAIL zero_carry got %0d exp %0d", carry_out, exp_co); else passed++;
   endtask

   // Generic one-shot conversion check used by the value-pattern scenarios.
   task automatic test_pattern(input string name, input bit junk);
      int lat;
      make_bus(junk);
      compute_expected();
      pulse();
      wait_valid(lat);
      total++; if (lat !== LAT) $display("FAIL %s_latency got %0d exp %0d", name, lat, LAT); else passed++;
      total++;
      if (result !== exp_res)
         $display("FAIL %s_result word%0d got %h exp %h", name, first_diff(result, exp_res),
                  result[first_diff(result, exp_res)*WL +: WL], exp_res[first_diff(result, exp_res)*WL +: WL]);
      else passed++;
      total++; if (carry_out !== exp_co) $display("FAIL %s_carry got %0d exp %0d", name, carry_out, exp_co); else passed++;
   endtask

   task automatic test_single();
      for (int j = 0; j < NE; j++) coef[j] = '0;
      coef[0] = 17'h1FFFF;
      compute_expected();
      total++;
      if (exp_res[31:0] !== 32'h0001_FFFF) $display("FAIL single_model got %h exp 0001ffff", exp_res[31:0]); else passed++;
      test_pattern("single", 0);
   endtask

   task automatic test_all_ones();
      for (int j = 0; j < NE; j++) coef[j] = 17'h1FFFF;
      test_pattern("all_ones", 0);
      total++; if (carry_out !== 2'd2) $display("FAIL all_ones_carry2 got %0d exp 2", carry_out); else passed++;
   endtask

   task automatic test_upper_ignored();
      logic [RB-1:0] ones_res;
      ones_res = result;
      for (int j = 0; j < NE; j++) coef[j] = 17'h1FFFF;
      for (int j = 0; j < NE; j++) bus[j*32 +: 32] = 32'hFFFE_0000 | 32'h0001_FFFF;
      compute_expected();
      pulse();
      begin
         int lat;
         wait_valid(lat);
         total++; if (lat !== LAT) $display("FAIL upper_latency got %0d exp %0d", lat, LAT); else passed++;
      end
      total++; if (result !== exp_res) $display("FAIL upper_result word%0d differs", first_diff(result, exp_res)); else passed++;
      total++; if (result !== ones_res) $display("FAIL upper_vs_ones word%0d differs", first_diff(result, ones_res)); else passed++;
      // Random coefficients with random junk above bit 16.
      for (int j = 0; j < NE; j++) coef[j] = 17'($urandom);
      test_pattern("upper_junk", 1);
   endtask

   task automatic test_random();
      for (int n = 0; n < 4; n++) begin
         for (int j = 0; j < NE; j++)
            coef[j] = (n == 3) ? 17'($urandom_range(17'h1FFF0, 17'h1FFFF)) : 17'($urandom);
         test_pattern("random", 1);
      end
   endtask

   task automatic test_back_to_back();
      logic [RB-1:0]  res_b;
      logic [1:0]     co_b;
      logic [SQB-1:0] bus_b;
      int lat;
      for (int j = 0; j < NE; j++) coef[j] = 17'($urandom);
      make_bus(1);
      compute_expected();
      bus_b = bus; res_b = exp_res; co_b = exp_co;
      for (int j = 0; j < NE; j++) coef[j] = 17'($urandom);
      make_bus(1);
      compute_expected();
      pulse();
      wait_valid(lat);
      total++; if (result !== exp_res) $display("FAIL b2b_first word%0d differs", first_diff(result, exp_res)); else passed++;
      // First IDLE cycle after DONE: must be accepted.
      sq_in    = bus_b;
      sq_valid = 1'b1;
      @(negedge clk);
      sq_valid = 1'b0;
      wait_valid(lat);
      total++; if (lat !== LAT) $display("FAIL b2b_latency got %0d exp %0d", lat, LAT); else passed++;
      total++; if (result !== res_b) $display("FAIL b2b_second word%0d differs", first_diff(result, res_b)); else passed++;
      total++; if (carry_out !== co_b) $display("FAIL b2b_carry got %0d exp %0d", carry_out, co_b); else passed++;
      total++; if (overrun !== 1'b0) $display("FAIL b2b_overrun got %b exp 0", overrun); else passed++;
   endtask

   task automatic test_overrun();
      logic [RB-1:0] res_a;
      logic [1:0]    co_a;
      int lat;
      int extra;
      for (int j = 0; j < NE; j++) coef[j] = 17'($urandom);
      make_bus(1);
      compute_expected();
      res_a = exp_res; co_a = exp_co;
      pulse();
      repeat (9) @(negedge clk);
      for (int j = 0; j < NE; j++) coef[j] = 17'($urandom);
      make_bus(1);
      pulse();
      total++; if (overrun !== 1'b1) $display("FAIL overrun_set got %b exp 1", overrun); else passed++;
      wait_valid(lat);
      total++; if (lat !== LAT - 11) $display("FAIL overrun_latency got %0d exp %0d", lat, LAT - 11); else passed++;
      total++; if (result !== res_a) $display("FAIL overrun_result word%0d differs", first_diff(result, res_a)); else passed++;
      total++; if (carry_out !== co_a) $display("FAIL overrun_carry got %0d exp %0d", carry_out, co_a); else passed++;
      extra = 0;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         if (result_valid) extra++;
      end
      total++; if (extra !== 0) $display("FAIL overrun_extra_pulses got %0d exp 0", extra); else passed++;
      do_reset();
      total++; if (overrun !== 1'b0) $display("FAIL overrun_clear got %b exp 0", overrun); else passed++;
      total++; if (result !== '0) $display("FAIL overrun_reset_result word%0d nonzero", first_diff(result, '0)); else passed++;
   endtask

   task automatic test_abort();
      int lat;
      int stray;
      for (int j = 0; j < NE; j++) coef[j] = 17'($urandom);
      make_bus(1);
      pulse();
      repeat (30) @(negedge clk);
      reset = 1'b1;
      #1;
      total++; if (busy !== 1'b0) $display("FAIL abort_busy got %b exp 0", busy); else passed++;
      @(negedge clk);
      reset = 1'b0;
      stray = 0;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         if (result_valid) stray++;
      end
      total++; if (stray !== 0) $display("FAIL abort_stray_pulses got %0d exp 0", stray); else passed++;
      for (int j = 0; j < NE; j++) coef[j] = 17'($urandom);
      make_bus(1);
      compute_expected();
      pulse();
      wait_valid(lat);
      total++; if (lat !== LAT) $display("FAIL abort_new_latency got %0d exp %0d", lat, LAT); else passed++;
      total++; if (result !== exp_res) $display("FAIL abort_new_result word%0d differs", first_diff(result, exp_res)); else passed++;
      total++; if (carry_out !== exp_co) $display("FAIL abort_new_carry got %0d exp %0d", carry_out, exp_co); else passed++;
   endtask

   initial begin
      reset    = 1'b1;
      sq_valid = 1'b0;
      sq_in    = '0;
      bus      = '0;
      test_reset();
      test_zero();
      test_single();
      test_all_ones();
      test_upper_ignored();
      test_random();
      test_back_to_back();
      test_overrun();
      test_abort();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
